onehot_encoder_seq: RTL and testbench

//  Inverse of the 4-bit code decoder: accepts a WIDTH-bit request vector and emits,
//  one per handshake, the binary index of every set bit, lowest (or highest) first.
//  A single-bit (one-hot) vector yields exactly one code, the exact inverse of the decoder.

---
 rtl/onehot_encoder_seq.sv | 105 ++++++++++
 tb/tb_onehot_encoder_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: turns a request vector into a stream of set-bit indices,
// one per valid/ready beat; an all-zero vector yields a single error beat.
module onehot_encoder_seq #(
  parameter int WIDTH     = 16,
  parameter int CODE_W    = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic [CODE_W-1:0] sel_idx;
  logic [WIDTH-1:0]  sel_oh;
  logic              single;
  logic              emit, empty;

  // Last match in scan order wins, so scan away from the preferred end.
  always_comb begin
    sel_idx = '0;
    sel_oh  = '0;
    if (LSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          sel_idx   = CODE_W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pend_q[i]) begin
          sel_idx   = CODE_W'(i);
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
        end
      end
    end
  end

  assign single = (pend_q & (pend_q - WIDTH'(1))) == '0;

  // Outputs are masked by rst so nothing leaks while reset is held.
  assign emit      = (state_q == EMIT) && !rst;
  assign empty     = (state_q == EMPTY) && !rst;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = emit || empty;
  assign busy      = emit || empty;
  assign out_code  = emit ? sel_idx : '0;
  assign out_last  = (emit && single) || empty;
  assign out_err   = empty;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pend_d  = in_vec;
          state_d = (|in_vec) ? EMIT : EMPTY;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d = pend_q & ~sel_oh;
          if (single) state_d = IDLE;
        end
      end
      EMPTY: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// tb_onehot_encoder_seq: drives an LSB-first and an MSB-first instance and
// compares emitted beats against a list-based model of the set bits.
module tb_onehot_encoder_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        l_in_valid = 1'b0, m_in_valid = 1'b0;
  logic [15:0] l_in_vec = '0, m_in_vec = '0;
  logic        l_out_ready = 1'b0, m_out_ready = 1'b0;
  logic        l_in_ready, m_in_ready;
  logic        l_out_valid, m_out_valid;
  logic [3:0]  l_out_code, m_out_code;
  logic        l_out_last, m_out_last;
  logic        l_out_err, m_out_err;
  logic        l_busy, m_busy;

  always #5 clk = ~clk;

  onehot_encoder_seq #(.WIDTH(16), .CODE_W(4), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst),
    .in_valid(l_in_valid), .in_ready(l_in_ready), .in_vec(l_in_vec),
    .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_code(l_out_code), .out_last(l_out_last), .out_err(l_out_err),
    .busy(l_busy)
  );

  onehot_encoder_seq #(.WIDTH(16), .CODE_W(4), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_vec(m_in_vec),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_code(m_out_code), .out_last(m_out_last), .out_err(m_out_err),
    .busy(m_busy)
  );

  int checks = 0;
  int failures = 0;
  int q_code[$], q_last[$], q_err[$], q_cyc[$];
  int e_code[$];
  bit tmo;

  // Reference: the list of set-bit indices in emission order.
  task automatic model(input logic [15:0] v, input bit msb);
    e_code.delete();
    if (v == 16'h0) e_code.push_back(0);
    else
      for (int i = 0; i < 16; i++)
        if (v[i]) begin
          if (msb) e_code.push_front(i);
          else e_code.push_back(i);
        end
  endtask

  task automatic send(input bit m, input logic [15:0] v);
    int n = 0;
    tmo = 1'b0;
    @(negedge clk);
    if (m) begin m_in_valid = 1'b1; m_in_vec = v; end
    else begin l_in_valid = 1'b1; l_in_vec = v; end
    while (!(m ? m_in_ready : l_in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) tmo = 1'b1;
    @(posedge clk);
    #1;
    if (m) begin m_in_valid = 1'b0; m_in_vec = 16'($urandom); end
    else begin l_in_valid = 1'b0; l_in_vec = 16'($urandom); end
  endtask

  task automatic collect(input bit m, input bit rnd);
    int cyc = 0;
    bit done = 1'b0;
    bit rdy;
    q_code.delete(); q_last.delete(); q_err.delete(); q_cyc.delete();
    while (!done && cyc < 80) begin
      @(negedge clk);
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m) m_out_ready = rdy;
      else l_out_ready = rdy;
      if ((m ? m_out_valid : l_out_valid) && rdy) begin
        q_code.push_back(int'(m ? m_out_code : l_out_code));
        q_last.push_back(int'(m ? m_out_last : l_out_last));
        q_err.push_back(int'(m ? m_out_err : l_out_err));
        q_cyc.push_back(cyc);
        if (m ? m_out_last : l_out_last) done = 1'b1;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    m_out_ready = 1'b0;
    l_out_ready = 1'b0;
    if (!done) tmo = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b0 || l_out_valid !== 1'b0 || l_busy !== 1'b0 ||
        l_out_code !== 4'h0 || l_out_last !== 1'b0 || l_out_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold rdy=%b vld=%b busy=%b code=%h last=%b err=%b req=0",
               l_in_ready, l_out_valid, l_busy, l_out_code, l_out_last, l_out_err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_exit in_ready=%b/%b out_valid=%b req=1/1/0",
               l_in_ready, m_in_ready, l_out_valid);
    end
  endtask

  task automatic test_onehot;
    send(0, 16'h2000);
    collect(0, 0);
    checks++;
    if (tmo || q_code.size() != 1 || q_code[0] != 13 || q_last[0] != 1 ||
        q_err[0] != 0 || q_cyc[0] != 0) begin
      failures++;
      $display("FAIL onehot n=%0d code=%0d last=%0d err=%0d cyc=%0d tmo=%0b req 1/13/1/0/0",
               q_code.size(), q_code.size() ? q_code[0] : -1,
               q_last.size() ? q_last[0] : -1, q_err.size() ? q_err[0] : -1,
               q_cyc.size() ? q_cyc[0] : -1, tmo);
    end
  endtask

  task automatic test_multihot;
    send(0, 16'h0824);
    collect(0, 0);
    model(16'h0824, 0);
    checks++;
    if (tmo || q_code.size() != e_code.size()) begin
      failures++;
      $display("FAIL multihot_count got=%0d req=%0d tmo=%0b",
               q_code.size(), e_code.size(), tmo);
    end else
      foreach (e_code[k]) begin
        checks++;
        if (q_code[k] != e_code[k] || q_last[k] != int'(k == e_code.size() - 1) ||
            q_err[k] != 0 || q_cyc[k] != k) begin
          failures++;
          $display("FAIL multihot_beat%0d code=%0d last=%0d cyc=%0d req code=%0d cyc=%0d",
                   k, q_code[k], q_last[k], q_cyc[k], e_code[k], k);
        end
      end
  endtask

  task automatic test_backpressure;
    send(0, 16'h0C00);
    l_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (l_out_valid !== 1'b1 || l_out_code !== 4'd10 || l_out_last !== 1'b0 ||
          l_in_ready !== 1'b0 || l_busy !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold%0d vld=%b code=%0d last=%b in_ready=%b req 1/10/0/0",
                 k, l_out_valid, l_out_code, l_out_last, l_in_ready);
      end
    end
    collect(0, 0);
    checks++;
    if (tmo || q_code.size() != 2 || q_code[0] != 10 || q_code[1] != 11 ||
        q_last[0] != 0 || q_last[1] != 1) begin
      failures++;
      $display("FAIL bp_release n=%0d tmo=%0b req codes 10,11", q_code.size(), tmo);
    end
  endtask

  task automatic test_empty;
    send(0, 16'h0000);
    collect(0, 0);
    checks++;
    if (tmo || q_code.size() != 1 || q_code[0] != 0 || q_last[0] != 1 || q_err[0] != 1) begin
      failures++;
      $display("FAIL empty n=%0d code=%0d last=%0d err=%0d req 1/0/1/1",
               q_code.size(), q_code.size() ? q_code[0] : -1,
               q_last.size() ? q_last[0] : -1, q_err.size() ? q_err[0] : -1);
    end
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b1 || l_busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_idle in_ready=%b busy=%b req 1/0", l_in_ready, l_busy);
    end
  endtask

  task automatic test_reset_mid;
    int got[$];
    send(0, 16'hFFFF);
    l_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      got.push_back(l_out_valid ? int'(l_out_code) : -1);
      @(posedge clk);
    end
    #1 rst = 1'b1;
    l_out_ready = 1'b0;
    checks++;
    if (got[0] != 0 || got[1] != 1 || got[2] != 2) begin
      failures++;
      $display("FAIL rstmid_beats got=%0d,%0d,%0d req 0,1,2", got[0], got[1], got[2]);
    end
    @(negedge clk);
    checks++;
    if (l_out_valid !== 1'b0 || l_in_ready !== 1'b0 || l_busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_hold vld=%b in_ready=%b busy=%b req 0/0/0",
               l_out_valid, l_in_ready, l_busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_exit in_ready=%b vld=%b req 1/0", l_in_ready, l_out_valid);
    end
    send(0, 16'h0001);
    collect(0, 0);
    checks++;
    if (tmo || q_code.size() != 1 || q_code[0] != 0 || q_last[0] != 1 || q_err[0] != 0) begin
      failures++;
      $display("FAIL rstmid_next n=%0d code=%0d req single code 0",
               q_code.size(), q_code.size() ? q_code[0] : -1);
    end
  endtask

  task automatic test_back_to_back;
    send(0, 16'h0005);
    collect(0, 0);
    @(negedge clk);
    checks++;
    if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap in_ready=%b vld=%b req 1/0", l_in_ready, l_out_valid);
    end
    l_in_valid = 1'b1;
    l_in_vec   = 16'h0100;
    @(posedge clk);
    #1 l_in_valid = 1'b0;
    collect(0, 0);
    checks++;
    if (tmo || q_code.size() != 1 || q_code[0] != 8 || q_cyc[0] != 0) begin
      failures++;
      $display("FAIL b2b_next n=%0d code=%0d req single code 8 at cyc 0",
               q_code.size(), q_code.size() ? q_code[0] : -1);
    end
  endtask

  task automatic test_msb_first;
    send(1, 16'h8001);
    collect(1, 0);
    checks++;
    if (tmo || q_code.size() != 2 || q_code[0] != 15 || q_code[1] != 0 ||
        q_last[0] != 0 || q_last[1] != 1) begin
      failures++;
      $display("FAIL msb_8001 n=%0d first=%0d req 15 then 0",
               q_code.size(), q_code.size() ? q_code[0] : -1);
    end
  endtask

  task automatic test_sweep;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 16; i++) begin
        send(1'(m), 16'(1) << i);
        collect(1'(m), 0);
        checks++;
        if (tmo || q_code.size() != 1 || q_code[0] != i || q_last[0] != 1 || q_err[0] != 0) begin
          failures++;
          $display("FAIL sweep_m%0d_bit%0d n=%0d code=%0d req %0d",
                   m, i, q_code.size(), q_code.size() ? q_code[0] : -1, i);
        end
      end
  endtask

  task automatic test_random;
    logic [15:0] v;
    for (int t = 0; t < 40; t++) begin
      bit m = 1'(t & 1);
      case ($urandom_range(0, 3))
        0: v = 16'h0;
        1: v = 16'($urandom);
        2: v = 16'($urandom & $urandom & $urandom);
        default: v = 16'hFFFF;
      endcase
      send(m, v);
      collect(m, 1);
      model(v, m);
      checks++;
      if (tmo || q_code.size() != e_code.size()) begin
        failures++;
        $display("FAIL rand%0d_count vec=%h m=%0d got=%0d req=%0d tmo=%0b",
                 t, v, m, q_code.size(), e_code.size(), tmo);
      end else
        foreach (e_code[k]) begin
          checks++;
          if (q_code[k] != e_code[k] || q_last[k] != int'(k == e_code.size() - 1) ||
              q_err[k] != int'(v == 16'h0)) begin
            failures++;
            $display("FAIL rand%0d_beat%0d vec=%h code=%0d last=%0d err=%0d req code=%0d",
                     t, k, v, q_code[k], q_last[k], q_err[k], e_code[k]);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_multihot();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_back_to_back();
    test_msb_first();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
